// File: rtl/toothless_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Contents: writeback source enum, writeback request payload struct,
// default address/data widths and the default ALU starvation limit.
package toothless_pkg;

    localparam int unsigned RF_ADDR_W_DEF    = 5;
    localparam int unsigned RF_DATA_W_DEF    = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // Which requester owns the write port this cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

    // Writeback payload at the default widths.
    typedef struct packed {
        logic [RF_ADDR_W_DEF-1:0] waddr;
        logic [RF_DATA_W_DEF-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/read bundle between the execute/memory stages, the arbiter and
// the register file.
//   alu_*   : ALU writeback request (valid/ready handshake, addr, data)
//   lsu_*   : LSU writeback request (valid/ready handshake, addr, data)
//   rf_*_o  : register file write port driven by the arbiter
//   raddr_* / rf_rdata_* / rdata_* : decode read ports, raw and bypassed
// Modports: slave = arbiter view, master = requester/regfile/decode view.
interface regfile_wb_arbiter_if
    import toothless_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH = RF_DATA_W_DEF
);

    logic                  alu_valid_i;
    logic                  alu_ready_o;
    logic [ADDR_WIDTH-1:0] alu_waddr_i;
    logic [DATA_WIDTH-1:0] alu_wdata_i;

    logic                  lsu_valid_i;
    logic                  lsu_ready_o;
    logic [ADDR_WIDTH-1:0] lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;

    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;

    logic [ADDR_WIDTH-1:0] raddr_a_i;
    logic [ADDR_WIDTH-1:0] raddr_b_i;
    logic [DATA_WIDTH-1:0] rf_rdata_a_i;
    logic [DATA_WIDTH-1:0] rf_rdata_b_i;
    logic [DATA_WIDTH-1:0] rdata_a_o;
    logic [DATA_WIDTH-1:0] rdata_b_o;

    modport slave (
        input  alu_valid_i, alu_waddr_i, alu_wdata_i,
        output alu_ready_o,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output lsu_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        input  raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
        output rdata_a_o, rdata_b_o
    );

    modport master (
        output alu_valid_i, alu_waddr_i, alu_wdata_i,
        input  alu_ready_o,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  lsu_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        output raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
        input  rdata_a_o, rdata_b_o
    );

endinterface

// File: rtl/regfile_wb_arbiter_rf_bypass_mux.sv
// Read-port bypass: returns the in-flight write data when the pending write
// targets the register being read (x0 is never bypassed), else the raw
// register file data. Only built when TOOTHLESS_WB_BYPASS_EN is defined.
// Ports: rf_we_i/rf_waddr_i/rf_wdata_i (pending write), raddr_i, rf_rdata_i
// (raw read), rdata_o (resolved read data, combinational).
`ifdef TOOTHLESS_WB_BYPASS_EN
module rf_bypass_mux #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  rf_we_i,
    input  logic [ADDR_WIDTH-1:0] rf_waddr_i,
    input  logic [DATA_WIDTH-1:0] rf_wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic hit;

    always_comb begin
        hit     = rf_we_i && (rf_waddr_i == raddr_i) && (raddr_i != '0);
        rdata_o = hit ? rf_wdata_i : rf_rdata_i;
    end

endmodule
`endif

// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter. Shares the single write port between the
// ALU and the LSU: LSU has fixed priority, a starvation counter force-grants
// the ALU after STARVE_LIMIT consecutive stalled cycles. The granted write is
// registered onto the rf_* write port one cycle after acceptance; writes to
// x0 are accepted but never enable the write port.
// Ports: clk, rst_n (synchronous, active-low), bus (regfile_wb_arbiter_if
// slave modport: ALU/LSU handshakes, write port, read ports).
// Config: define TOOTHLESS_WB_BYPASS_EN to forward the in-flight write to
// both read ports; otherwise read data passes through unchanged.
module regfile_wb_arbiter
    import toothless_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = RF_ADDR_W_DEF,
    parameter int unsigned DATA_WIDTH   = RF_DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    wb_src_e               grant;
    logic                  starve_at_limit;

    logic [CNT_W-1:0]      starve_cnt_d,  starve_cnt_q;
    logic                  rf_we_d,       rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_d,    rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_d,    rf_wdata_q;

    // Fixed-priority grant with ALU force-grant once it has waited long enough.
    always_comb begin
        grant           = WB_NONE;
        starve_at_limit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        if (bus.alu_valid_i && bus.lsu_valid_i) begin
            grant = starve_at_limit ? WB_ALU : WB_LSU;
        end else if (bus.alu_valid_i) begin
            grant = WB_ALU;
        end else if (bus.lsu_valid_i) begin
            grant = WB_LSU;
        end
    end

    // Ready mirrors the grant and is forced low while reset is asserted.
    assign bus.alu_ready_o = rst_n && (grant == WB_ALU);
    assign bus.lsu_ready_o = rst_n && (grant == WB_LSU);

    // Next-state for the starvation counter and the write-port register.
    always_comb begin
        starve_cnt_d = '0;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;

        if (bus.alu_valid_i && (grant != WB_ALU)) begin
            starve_cnt_d = starve_at_limit ? starve_cnt_q
                                           : starve_cnt_q + CNT_W'(1);
        end

        unique case (grant)
            WB_ALU: begin
                rf_waddr_d = bus.alu_waddr_i;
                rf_wdata_d = bus.alu_wdata_i;
                rf_we_d    = (bus.alu_waddr_i != '0);
            end
            WB_LSU: begin
                rf_waddr_d = bus.lsu_waddr_i;
                rf_wdata_d = bus.lsu_wdata_i;
                rf_we_d    = (bus.lsu_waddr_i != '0);
            end
            default: ;
        endcase
    end

    // State register; synchronous reset cancels any pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign bus.rf_we_o    = rf_we_q;
    assign bus.rf_waddr_o = rf_waddr_q;
    assign bus.rf_wdata_o = rf_wdata_q;

`ifdef TOOTHLESS_WB_BYPASS_EN
    // Forward the in-flight write so decode sees it in the same cycle.
    rf_bypass_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bypass_a (
        .rf_we_i    (rf_we_q),
        .rf_waddr_i (rf_waddr_q),
        .rf_wdata_i (rf_wdata_q),
        .raddr_i    (bus.raddr_a_i),
        .rf_rdata_i (bus.rf_rdata_a_i),
        .rdata_o    (bus.rdata_a_o)
    );

    rf_bypass_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bypass_b (
        .rf_we_i    (rf_we_q),
        .rf_waddr_i (rf_waddr_q),
        .rf_wdata_i (rf_wdata_q),
        .raddr_i    (bus.raddr_b_i),
        .rf_rdata_i (bus.rf_rdata_b_i),
        .rdata_o    (bus.rdata_b_o)
    );
`else
    // Straight pass-through; read addresses are not needed here.
    logic unused_raddr;
    assign unused_raddr  = ^{bus.raddr_a_i, bus.raddr_b_i};
    assign bus.rdata_a_o = bus.rf_rdata_a_i;
    assign bus.rdata_b_o = bus.rf_rdata_b_i;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: reset behaviour, single and
// contending requests, ALU starvation guarantee, x0 discard, same-register
// serialization, read-port forwarding and reset mid-operation.
module tb_regfile_wb_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    regfile_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

    regfile_wb_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        wb.alu_valid_i = av;
        wb.alu_waddr_i = aa;
        wb.alu_wdata_i = ad;
        wb.lsu_valid_i = lv;
        wb.lsu_waddr_i = la;
        wb.lsu_wdata_i = ld;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b1, 5'd2, 32'hBBBB_0002, 1'b1, 5'd1, 32'hAAAA_0001);
        wb.raddr_a_i    = '0;
        wb.raddr_b_i    = '0;
        wb.rf_rdata_a_i = '0;
        wb.rf_rdata_b_i = '0;

        // Reset held with both requests pending.
        @(negedge clk); #1;
        check("rst_alu_ready", 32'(wb.alu_ready_o), 32'd0);
        check("rst_lsu_ready", 32'(wb.lsu_ready_o), 32'd0);
        @(posedge clk); #1;
        check("rst_we",     32'(wb.rf_we_o),    32'd0);
        check("rst_waddr",  32'(wb.rf_waddr_o), 32'd0);
        check("rst_wdata",  wb.rf_wdata_o,      32'd0);
        check("rst_starve", 32'(dut.starve_cnt_q), 32'd0);

        // Release: LSU wins the first cycle.
        @(negedge clk); rst_n = 1'b1; #1;
        check("rel_lsu_ready", 32'(wb.lsu_ready_o), 32'd1);
        check("rel_alu_ready", 32'(wb.alu_ready_o), 32'd0);
        @(posedge clk); #1;
        check("rel_we",    32'(wb.rf_we_o),    32'd1);
        check("rel_waddr", 32'(wb.rf_waddr_o), 32'd1);
        check("rel_wdata", wb.rf_wdata_o,      32'hAAAA_0001);
        check("rel_starve", 32'(dut.starve_cnt_q), 32'd1);

        // LSU done; held ALU request goes through.
        @(negedge clk); drive(1'b1, 5'd2, 32'hBBBB_0002, 1'b0, 5'd0, 32'd0); #1;
        check("held_alu_ready", 32'(wb.alu_ready_o), 32'd1);
        @(posedge clk); #1;
        check("held_waddr",  32'(wb.rf_waddr_o), 32'd2);
        check("held_wdata",  wb.rf_wdata_o,      32'hBBBB_0002);
        check("held_starve", 32'(dut.starve_cnt_q), 32'd0);

        // ALU alone.
        @(negedge clk); drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0); #1;
        check("alu_ready", 32'(wb.alu_ready_o), 32'd1);
        check("alu_lsu_ready", 32'(wb.lsu_ready_o), 32'd0);
        @(posedge clk); #1;
        check("alu_we",    32'(wb.rf_we_o),    32'd1);
        check("alu_waddr", 32'(wb.rf_waddr_o), 32'd5);
        check("alu_wdata", wb.rf_wdata_o,      32'hDEAD_BEEF);

        // Idle: write enable drops, addr/data hold.
        @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); #1;
        check("idle_ready", 32'({wb.alu_ready_o, wb.lsu_ready_o}), 32'd0);
        @(posedge clk); #1;
        check("idle_we",    32'(wb.rf_we_o),    32'd0);
        check("idle_waddr", 32'(wb.rf_waddr_o), 32'd5);
        check("idle_wdata", wb.rf_wdata_o,      32'hDEAD_BEEF);

        // Continuous contention: LSU 4 cycles, then ALU force-granted.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd10, 32'h100 + 32'(i));
            #1;
            check($sformatf("starve_lsu_ready_%0d", i), 32'(wb.lsu_ready_o), (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("starve_alu_ready_%0d", i), 32'(wb.alu_ready_o), (i == 4) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            check($sformatf("starve_cnt_%0d", i), 32'(dut.starve_cnt_q), (i < 4) ? 32'(i + 1) : 32'd0);
            check($sformatf("starve_waddr_%0d", i), 32'(wb.rf_waddr_o), (i < 4) ? 32'd10 : 32'd9);
            check($sformatf("starve_wdata_%0d", i), wb.rf_wdata_o,
                  (i < 4) ? (32'h100 + 32'(i)) : 32'h0000_0099);
        end

        // LSU write to x0: accepted, write port stays disabled.
        @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFE_0000); #1;
        check("x0_lsu_ready", 32'(wb.lsu_ready_o), 32'd1);
        @(posedge clk); #1;
        check("x0_we",    32'(wb.rf_we_o),    32'd0);
        check("x0_waddr", 32'(wb.rf_waddr_o), 32'd0);

        // Same destination x3: LSU lands first, ALU last.
        @(negedge clk); drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22); #1;
        check("x3_first_lsu", 32'(wb.lsu_ready_o), 32'd1);
        @(posedge clk); #1;
        check("x3_first_we",   32'(wb.rf_we_o),    32'd1);
        check("x3_first_data", wb.rf_wdata_o,      32'h22);
        @(negedge clk); drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0); #1;
        check("x3_second_alu", 32'(wb.alu_ready_o), 32'd1);
        @(posedge clk); #1;
        check("x3_second_we",    32'(wb.rf_we_o),    32'd1);
        check("x3_second_waddr", 32'(wb.rf_waddr_o), 32'd3);
        check("x3_final_data",   wb.rf_wdata_o,      32'h11);

        // Read ports while x7 = 0x1234 is in flight.
        @(negedge clk); drive(1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        wb.raddr_a_i    = 5'd7;
        wb.rf_rdata_a_i = 32'd0;
        wb.raddr_b_i    = 5'd7;
        wb.rf_rdata_b_i = 32'h55;
        #1;
`ifdef TOOTHLESS_WB_BYPASS_EN
        check("byp_a_hit", wb.rdata_a_o, 32'h1234);
        check("byp_b_hit", wb.rdata_b_o, 32'h1234);
`else
        check("byp_a_pass", wb.rdata_a_o, 32'd0);
        check("byp_b_pass", wb.rdata_b_o, 32'h55);
`endif
        wb.raddr_a_i    = 5'd0;
        wb.rf_rdata_a_i = 32'hAAAA;
        #1;
        check("byp_a_x0", wb.rdata_a_o, 32'hAAAA);

        // Reset mid-operation cancels the pending write.
        @(negedge clk); drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        check("mid_we_before", 32'(wb.rf_we_o), 32'd1);
        @(negedge clk); rst_n = 1'b0; #1;
        check("mid_rst_ready", 32'(wb.alu_ready_o), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_we",    32'(wb.rf_we_o),    32'd0);
        check("mid_rst_waddr", 32'(wb.rf_waddr_o), 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        check("mid_rearb_ready", 32'(wb.alu_ready_o), 32'd1);
        @(posedge clk); #1;
        check("mid_rearb_waddr", 32'(wb.rf_waddr_o), 32'd4);
        check("mid_rearb_wdata", wb.rf_wdata_o,      32'h44);

        @(negedge clk); drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
